// File: rtl/move_pkg.sv
// rtl/move_pkg.sv - direction encodings and FSM state type shared by the move query scheduler
package move_pkg;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_U = 2'd1,
    DIR_D = 2'd2,
    DIR_L = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic logic [3:0] dir_onehot(input dir_e d);
    case (d)
      DIR_R:   dir_onehot = DIR_RIGHT;
      DIR_U:   dir_onehot = DIR_UP;
      DIR_D:   dir_onehot = DIR_DOWN;
      default: dir_onehot = DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick; the search starts at ptr and wraps
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any_req
);

  logic found;

  always_comb begin
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[ID_W'((int'(ptr) + i) % NUM_REQ)]) begin
        found  = 1'b1;
        gnt_id = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/move_query_scheduler.sv
// rtl/move_query_scheduler.sv - arbitrates agent move queries and reads the 4 neighbour wall bits
// Optional horizontal tunnel wrap-around is enabled by defining WRAP_TUNNEL_EN.
module move_query_scheduler
  import move_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TILE_SHIFT = 4,
  parameter int MAP_W      = 40,
  parameter int MAP_H      = 30,
  parameter int ADDR_W     = 11,
  parameter int ID_W       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*11-1:0] req_pos_x,
  input  logic [NUM_REQ*10-1:0] req_pos_y,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_rdata,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_moves
);

  localparam logic [10:0] X_LAST = 11'(MAP_W - 1);
  localparam logic [9:0]  Y_LAST = 10'(MAP_H - 1);

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [10:0]       tile_x_q, tile_x_d;
  logic [9:0]        tile_y_q, tile_y_d;
  logic [3:0]        moves_q, moves_d;
  logic              pend_cap_q, pend_vld_q;
  dir_e              pend_dir_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [3:0]        rsp_moves_q, rsp_moves_d;

  logic [ID_W-1:0]   gnt_id;
  logic              any_req;
  logic [10:0]       pos_x_sel;
  logic [9:0]        pos_y_sel;
  logic [10:0]       nb_x;
  logic [9:0]        nb_y;
  logic              nb_ok, tile_ok;
  logic [3:0]        moves_cap, cap_oh;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_id  (gnt_id),
    .any_req (any_req)
  );

  assign pos_x_sel = req_pos_x[int'(gnt_id)*11 +: 11];
  assign pos_y_sel = req_pos_y[int'(gnt_id)*10 +: 10];
  assign tile_ok   = (tile_x_q < 11'(MAP_W)) && (tile_y_q < 10'(MAP_H));

  // Neighbour tile of the current direction; nb_ok drops at map edges without a wrap.
  always_comb begin
    nb_x  = tile_x_q;
    nb_y  = tile_y_q;
    nb_ok = 1'b1;
    case (dir_q)
      DIR_R: begin
        if (tile_x_q == X_LAST) begin
`ifdef WRAP_TUNNEL_EN
          nb_x = '0;
`else
          nb_ok = 1'b0;
`endif
        end else begin
          nb_x = tile_x_q + 11'd1;
        end
      end
      DIR_U: begin
        if (tile_y_q == '0) nb_ok = 1'b0;
        else                nb_y  = tile_y_q - 10'd1;
      end
      DIR_D: begin
        if (tile_y_q == Y_LAST) nb_ok = 1'b0;
        else                    nb_y  = tile_y_q + 10'd1;
      end
      default: begin
        if (tile_x_q == '0) begin
`ifdef WRAP_TUNNEL_EN
          nb_x = X_LAST;
`else
          nb_ok = 1'b0;
`endif
        end else begin
          nb_x = tile_x_q - 11'd1;
        end
      end
    endcase
  end

  assign mem_rd_en = (state_q == ST_ISSUE) && tile_ok && nb_ok;
  assign mem_addr  = mem_rd_en ? ADDR_W'(int'(nb_y) * MAP_W + int'(nb_x)) : '0;

  // The BRAM bit for the read issued last cycle is valid now; skipped reads capture 0.
  always_comb begin
    cap_oh    = dir_onehot(pend_dir_q);
    moves_cap = moves_q;
    if (pend_cap_q)
      moves_cap = (moves_q & ~cap_oh) | ({4{pend_vld_q & ~mem_rdata}} & cap_oh);
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    id_d        = id_q;
    rr_ptr_d    = rr_ptr_q;
    tile_x_d    = tile_x_q;
    tile_y_d    = tile_y_q;
    moves_d     = moves_cap;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_moves_d = rsp_moves_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          id_d     = gnt_id;
          tile_x_d = pos_x_sel >> TILE_SHIFT;
          tile_y_d = pos_y_sel >> TILE_SHIFT;
          moves_d  = '0;
          dir_d    = DIR_R;
          rr_ptr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dir_d = dir_e'(dir_q + 2'd1);
        if (dir_q == DIR_L) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_moves_d = moves_cap;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_R;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      tile_x_q    <= '0;
      tile_y_q    <= '0;
      moves_q     <= '0;
      pend_cap_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_dir_q  <= DIR_R;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_moves_q <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      tile_x_q    <= tile_x_d;
      tile_y_q    <= tile_y_d;
      moves_q     <= moves_d;
      pend_cap_q  <= (state_q == ST_ISSUE);
      pend_vld_q  <= mem_rd_en;
      pend_dir_q  <= dir_q;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_moves_q <= rsp_moves_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_moves = rsp_moves_q;

endmodule
